// File: rtl/smp_mem_arbiter_if.sv
// Bus bundle between the per-hart core wrappers, the SMP memory arbiter and the memory controller.
interface smp_mem_arbiter_if #(
  parameter int NCORE = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int RW    = 128
);
  // Handshake: a hart raises req_valid[i] and holds it, with stable ctrl/addr/wdata,
  // until done[i] pulses. grant marks the current owner. mc_req is a one-cycle issue
  // pulse. mc_done is a one-cycle completion pulse. Neither side back-pressures.
  logic [NCORE-1:0]    req_valid;
  logic [3*NCORE-1:0]  req_ctrl;
  logic [AW*NCORE-1:0] req_addr;
  logic [DW*NCORE-1:0] req_wdata;
  logic [NCORE-1:0]    req_is_amo;
  logic [NCORE-1:0]    grant;
  logic [NCORE-1:0]    done;
  logic [RW-1:0]       rdata;
  logic                locked;
  logic                mc_req;
  logic [2:0]          mc_ctrl;
  logic [AW-1:0]       mc_addr;
  logic [DW-1:0]       mc_wdata;
  logic                mc_done;
  logic [RW-1:0]       mc_rdata;

  modport master (
    input  req_valid, req_ctrl, req_addr, req_wdata, req_is_amo, mc_done, mc_rdata,
    output grant, done, rdata, locked, mc_req, mc_ctrl, mc_addr, mc_wdata
  );

  modport slave (
    output req_valid, req_ctrl, req_addr, req_wdata, req_is_amo, mc_done, mc_rdata,
    input  grant, done, rdata, locked, mc_req, mc_ctrl, mc_addr, mc_wdata
  );
endinterface

// File: rtl/smp_mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller port between NCORE harts, with AMO lock.
// Optional watchdog on the controller response is enabled by defining SMP_ARB_WATCHDOG_EN.
module smp_mem_arbiter #(
  parameter int NCORE = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int RW    = 128
) (
  input  logic                clk,
  input  logic                rst,
  smp_mem_arbiter_if.master   bus,
`ifdef SMP_ARB_WATCHDOG_EN
  output logic                wd_err,
`endif
  output logic [1:0]          state_dbg
);
  localparam int IW = (NCORE > 1) ? $clog2(NCORE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
  state_t state, state_nxt;

  logic [NCORE-1:0] grant_q, done_q, sel_onehot;
  logic [RW-1:0]    rdata_q;
  logic             mc_req_q, locked_q;
  logic [2:0]       mc_ctrl_q, sel_ctrl;
  logic [AW-1:0]    mc_addr_q, sel_addr;
  logic [DW-1:0]    mc_wdata_q, sel_wdata;
  logic [IW-1:0]    last_q, owner_q, rr_idx, sel_idx;
  logic             rr_found, owner_amo, owner_valid, lock_hold, pick, wd_fire;
  int               rr_dist, rr_best;

  // Grant is one-hot of the owner whenever it is non-zero, so it doubles as the owner mask.
  assign owner_amo   = |(bus.req_is_amo & grant_q);
  assign owner_valid = |(bus.req_valid & grant_q);
  assign lock_hold   = locked_q && owner_amo;

  // Round-robin: smallest rotational distance from last+1 among the valid harts.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_best  = NCORE;
    rr_dist  = 0;
    for (int i = 0; i < NCORE; i++) begin
      rr_dist = i - int'(last_q) - 1;
      if (rr_dist < 0) rr_dist = rr_dist + NCORE;
      if (bus.req_valid[i] && rr_dist < rr_best) begin
        rr_best  = rr_dist;
        rr_found = 1'b1;
        rr_idx   = IW'(i);
      end
    end
  end

  assign pick    = lock_hold ? owner_valid : rr_found;
  assign sel_idx = lock_hold ? owner_q : rr_idx;

  always_comb begin
    sel_onehot = '0;
    sel_ctrl   = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    for (int i = 0; i < NCORE; i++) begin
      if (sel_idx == IW'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_ctrl      = bus.req_ctrl[3*i +: 3];
        sel_addr      = bus.req_addr[AW*i +: AW];
        sel_wdata     = bus.req_wdata[DW*i +: DW];
      end
    end
  end

`ifdef SMP_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;
  assign wd_fire = (state == ST_WAIT) && !bus.mc_done && (wd_cnt == 16'hFFFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      if (state == ST_ISSUE) wd_cnt <= '0;
      else if (state == ST_WAIT && !bus.mc_done) wd_cnt <= wd_cnt + 16'd1;
      if (wd_fire) wd_err <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (pick) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (bus.mc_done || wd_fire) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      mc_req_q   <= 1'b0;
      mc_ctrl_q  <= '0;
      mc_addr_q  <= '0;
      mc_wdata_q <= '0;
      locked_q   <= 1'b0;
      last_q     <= IW'(NCORE - 1);
      owner_q    <= '0;
    end else begin
      mc_req_q <= 1'b0;
      done_q   <= '0;
      unique case (state)
        ST_IDLE: begin
          // A released lock lets normal arbitration run in this same cycle.
          if (locked_q && !owner_amo) locked_q <= 1'b0;
          if (pick) begin
            grant_q    <= sel_onehot;
            owner_q    <= sel_idx;
            mc_ctrl_q  <= sel_ctrl;
            mc_addr_q  <= sel_addr;
            mc_wdata_q <= sel_wdata;
            mc_req_q   <= 1'b1;
          end else if (!lock_hold) begin
            grant_q <= '0;
          end
        end
        ST_ISSUE: ;
        ST_WAIT: begin
          if (bus.mc_done) begin
            rdata_q <= bus.mc_rdata;
            done_q  <= grant_q;
          end else if (wd_fire) begin
            rdata_q <= '0;
            done_q  <= grant_q;
          end
        end
        ST_RESP: begin
          last_q   <= owner_q;
          locked_q <= owner_amo;
          if (!owner_amo) grant_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.mc_req   = mc_req_q;
  assign bus.mc_ctrl  = mc_ctrl_q;
  assign bus.mc_addr  = mc_addr_q;
  assign bus.mc_wdata = mc_wdata_q;
  assign bus.locked   = locked_q;
  assign state_dbg    = state;
endmodule

// File: tb/tb_smp_mem_arbiter.sv
// Directed bench for smp_mem_arbiter: cycle vector table plus hand sequences for
// contention, AMO lock, reset in WAIT and (when SMP_ARB_WATCHDOG_EN is defined) the watchdog.
module tb_smp_mem_arbiter;
  localparam int NCORE = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int RW    = 128;

  localparam logic [AW-1:0] ADDR0 = 32'h0000_1000;
  localparam logic [AW-1:0] ADDR1 = 32'h0000_2000;
  localparam logic [DW-1:0] WD0   = 32'hDEAD_0000;
  localparam logic [DW-1:0] WD1   = 32'hBEEF_0001;
  localparam logic [2:0]    CTRL0 = 3'd1;
  localparam logic [2:0]    CTRL1 = 3'd2;
  localparam logic [RW-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [RW-1:0] PAT_5A = {16{8'h5A}};

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  smp_mem_arbiter_if #(.NCORE(NCORE), .AW(AW), .DW(DW), .RW(RW)) bus ();

`ifdef SMP_ARB_WATCHDOG_EN
  logic wd_err;
  smp_mem_arbiter #(.NCORE(NCORE), .AW(AW), .DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .bus(bus.master), .wd_err(wd_err), .state_dbg(state_dbg)
  );
`else
  smp_mem_arbiter #(.NCORE(NCORE), .AW(AW), .DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .bus(bus.master), .state_dbg(state_dbg)
  );
`endif

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [1:0]    rv;
    logic          mcd;
    logic [RW-1:0] mrd;
    logic [1:0]    g;
    logic [1:0]    d;
    logic          mreq;
    logic [RW-1:0] rd;
    logic [AW-1:0] addr;
    logic [1:0]    st;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"},    bus.grant,    '0);
    check({tag, "_done"},     bus.done,     '0);
    check({tag, "_rdata"},    bus.rdata,    '0);
    check({tag, "_mc_req"},   bus.mc_req,   '0);
    check({tag, "_mc_ctrl"},  bus.mc_ctrl,  '0);
    check({tag, "_mc_addr"},  bus.mc_addr,  '0);
    check({tag, "_mc_wdata"}, bus.mc_wdata, '0);
    check({tag, "_locked"},   bus.locked,   '0);
    check({tag, "_state"},    state_dbg,    '0);
  endtask

  // One full transaction for the hart in exp_g, answering with data after one WAIT cycle.
  task automatic do_txn(input logic [1:0] exp_g, input logic [RW-1:0] data);
    int k;
    k = 0;
    while (bus.mc_req !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check("issue_seen", bus.mc_req, 1'b1);
    check("grant", bus.grant, exp_g);
    check("mc_addr", bus.mc_addr, exp_g[1] ? ADDR1 : ADDR0);
    check("done_in_issue", bus.done, '0);
    step();
    check("state_wait", state_dbg, 2'd2);
    bus.mc_done  = 1'b1;
    bus.mc_rdata = data;
    step();
    bus.mc_done = 1'b0;
    check("done_owner", bus.done, exp_g);
    check("rdata", bus.rdata, data);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    // T1 single request, T4 stray mc_done while idle
    vecs[0] = '{2'b01, 1'b0, '0,     2'b01, 2'b00, 1'b1, '0,     ADDR0, 2'd1};
    vecs[1] = '{2'b01, 1'b0, '0,     2'b01, 2'b00, 1'b0, '0,     ADDR0, 2'd2};
    vecs[2] = '{2'b01, 1'b0, '0,     2'b01, 2'b00, 1'b0, '0,     ADDR0, 2'd2};
    vecs[3] = '{2'b01, 1'b0, '0,     2'b01, 2'b00, 1'b0, '0,     ADDR0, 2'd2};
    vecs[4] = '{2'b01, 1'b0, '0,     2'b01, 2'b00, 1'b0, '0,     ADDR0, 2'd2};
    vecs[5] = '{2'b01, 1'b1, PAT_A5, 2'b01, 2'b01, 1'b0, PAT_A5, ADDR0, 2'd3};
    vecs[6] = '{2'b00, 1'b0, '0,     2'b00, 2'b00, 1'b0, PAT_A5, ADDR0, 2'd0};
    vecs[7] = '{2'b00, 1'b1, PAT_5A, 2'b00, 2'b00, 1'b0, PAT_A5, ADDR0, 2'd0};
    vecs[8] = '{2'b00, 1'b0, '0,     2'b00, 2'b00, 1'b0, PAT_A5, ADDR0, 2'd0};

    bus.req_valid  = '0;
    bus.req_is_amo = '0;
    bus.req_ctrl   = {CTRL1, CTRL0};
    bus.req_addr   = {ADDR1, ADDR0};
    bus.req_wdata  = {WD1, WD0};
    bus.mc_done    = 1'b0;
    bus.mc_rdata   = '0;
    rst = 1'b1;
    step(); step(); step();
    check_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      bus.req_valid = vecs[i].rv;
      bus.mc_done   = vecs[i].mcd;
      bus.mc_rdata  = vecs[i].mrd;
      step();
      check($sformatf("v%0d_grant", i),   bus.grant,   vecs[i].g);
      check($sformatf("v%0d_done", i),    bus.done,    vecs[i].d);
      check($sformatf("v%0d_mc_req", i),  bus.mc_req,  vecs[i].mreq);
      check($sformatf("v%0d_rdata", i),   bus.rdata,   vecs[i].rd);
      check($sformatf("v%0d_mc_addr", i), bus.mc_addr, vecs[i].addr);
      check($sformatf("v%0d_state", i),   state_dbg,   vecs[i].st);
    end
    bus.mc_done = 1'b0;
    check("t1_mc_ctrl",  bus.mc_ctrl,  CTRL0);
    check("t1_mc_wdata", bus.mc_wdata, WD0);

    // T5 reset asserted in WAIT with a simultaneous mc_done; hart 0 was last owner before it
    bus.req_valid = 2'b01;
    step();
    check("t5_mc_req", bus.mc_req, 1'b1);
    step();
    check("t5_in_wait", state_dbg, 2'd2);
    rst           = 1'b1;
    bus.mc_done   = 1'b1;
    bus.mc_rdata  = PAT_5A;
    bus.req_valid = 2'b11;
    step();
    check_reset_vals("t5");
    rst         = 1'b0;
    bus.mc_done = 1'b0;

    // T2 contention from reset: strict rotation
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int n = 0; exp_q.size() > 0; n++) begin
      logic [1:0] g;
      g = exp_q.pop_front();
      do_txn(g, {4{24'h100000 + 24'(n), 8'h3C}});
    end

    // T3 AMO lock held by hart 1 across two requests while hart 0 keeps requesting
    step();
    bus.req_is_amo = 2'b10;
    do_txn(2'b01, {8{16'h0101}});
    do_txn(2'b10, {8{16'h0202}});
    step();
    check("t3_locked_between", bus.locked, 1'b1);
    check("t3_grant_held", bus.grant, 2'b10);
    step();
    check("t3_back_to_back_issue", bus.mc_req, 1'b1);
    check("t3_back_to_back_grant", bus.grant, 2'b10);
    do_txn(2'b10, {8{16'h0303}});
    bus.req_valid = 2'b01;
    step();
    check("t3_still_locked", bus.locked, 1'b1);
    step();
    check("t3_hart0_blocked_req", bus.mc_req, 1'b0);
    check("t3_hart0_blocked_grant", bus.grant, 2'b10);
    bus.req_is_amo = 2'b00;
    step();
    check("t3_release_grant", bus.grant, 2'b01);
    check("t3_release_locked", bus.locked, 1'b0);
    check("t3_release_issue", bus.mc_req, 1'b1);
    do_txn(2'b01, {8{16'h0404}});
    bus.req_valid = 2'b00;
    step();

`ifdef SMP_ARB_WATCHDOG_EN
    // T6 controller never answers
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_wd_err_reset", wd_err, 1'b0);
    bus.req_valid = 2'b01;
    begin
      int k;
      k = 0;
      while (bus.done === 2'b00 && k < 70000) begin
        step();
        k++;
      end
    end
    check("t6_done_owner", bus.done, 2'b01);
    check("t6_rdata_zero", bus.rdata, '0);
    check("t6_wd_err", wd_err, 1'b1);
    bus.req_valid = 2'b00;
    step(); step(); step();
    check("t6_wd_err_sticky", wd_err, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_wd_err_cleared", wd_err, 1'b0);
`endif

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
